// File: rtl/exec_pkg.sv
// exec_pkg: opcode and state encodings plus decode helpers for exec_responder
// Exports op_e (12 legal opcodes, 12-15 illegal), state_e, is_branch(), writes_rd().
package exec_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT,
    OP_MUL, OP_BEQ, OP_BNE, OP_BLT
  } op_e;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MULT, S_WB, S_DONE} state_e;
  function automatic logic is_branch(logic [3:0] op);
    return op == OP_BEQ || op == OP_BNE || op == OP_BLT;
  endfunction
  function automatic logic writes_rd(logic [3:0] op);
    return op <= OP_MUL;
  endfunction
endpackage

// File: rtl/exec_mul_iter.sv
// exec_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle
// Ports: clk, reset (sync, active-low), start_i loads a_i/b_i, busy_o high for
// XLEN cycles, last_o marks the final cycle, prod_o is the low XLEN product bits.
module exec_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            last_o,
  output logic [XLEN-1:0] prod_o
);
  localparam int CW = $clog2(XLEN);
  logic [XLEN-1:0] a_q, b_q, acc_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  // prod_o already folds in the current bit, so it is the full product while last_o
  assign prod_o = acc_q + (b_q[0] ? a_q : '0);
  assign last_o = cnt_q == CW'(XLEN - 1);
  assign busy_o = busy_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q  <= prod_o;
      a_q    <= a_q << 1;
      b_q    <= b_q >> 1;
      cnt_q  <= cnt_q + 1'b1;
      busy_q <= !last_o;
    end
  end
endmodule

// File: rtl/exec_responder.sv
// exec_responder: execute-side responder running ALU/MUL/branch ops for the sequencer
// Ports: clk, reset (sync, active-low), run (rise starts an op), op/rs1_val/rs2_val/
// imm/use_imm/rd_addr operands; rd_we/rd_waddr/rd_wdata register-file write;
// branch/err valid with the one-cycle done pulse; busy from DECODE through DONE.
module exec_responder
  import exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       op,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  imm,
  input  logic             use_imm,
  input  logic [RADDR-1:0] rd_addr,
  output logic             rd_we,
  output logic [RADDR-1:0] rd_waddr,
  output logic [XLEN-1:0]  rd_wdata,
  output logic             branch,
  output logic             done,
  output logic             busy,
  output logic             err
);
  localparam int SW = $clog2(XLEN);
  state_e           state_q;
  logic             run_q, rd_we_q, branch_q, done_q, err_q;
  logic [3:0]       op_q;
  logic [XLEN-1:0]  a_q, b_q, rd_wdata_q, alu_res, mul_prod;
  logic [RADDR-1:0] rd_q, rd_waddr_q;
  logic             mul_busy, mul_last, lt, br_d, wb_go;
  assign lt   = $signed(a_q) < $signed(b_q);
  assign br_d = is_branch(op_q) && (op_q == OP_BEQ ? a_q == b_q : op_q == OP_BNE ? a_q != b_q : lt);
  always_comb begin
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLL:  alu_res = a_q << b_q[SW-1:0];
      OP_SRL:  alu_res = a_q >> b_q[SW-1:0];
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt};
      default: alu_res = '0;
    endcase
  end
  exec_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start_i (state_q == S_DECODE && op_q == OP_MUL),
    .a_i     (a_q),
    .b_i     (b_q),
    .busy_o  (mul_busy),
    .last_o  (mul_last),
    .prod_o  (mul_prod)
  );
  // Result is latched on entry to WB so the write strobe is a registered output
  assign wb_go = state_q == S_EXEC || (state_q == S_MULT && mul_busy && mul_last);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      rd_waddr_q <= '0;
      rd_wdata_q <= '0;
      branch_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      run_q    <= run;
      rd_we_q  <= 1'b0;
      branch_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      if (wb_go && writes_rd(op_q) && rd_q != '0) begin
        rd_we_q    <= 1'b1;
        rd_waddr_q <= rd_q;
        rd_wdata_q <= state_q == S_MULT ? mul_prod : alu_res;
      end
      case (state_q)
        S_IDLE: if (run && !run_q) begin
          op_q    <= op;
          a_q     <= rs1_val;
          b_q     <= use_imm ? imm : rs2_val;
          rd_q    <= rd_addr;
          state_q <= S_DECODE;
        end
        S_DECODE: state_q <= op_q == OP_MUL ? S_MULT : S_EXEC;
        S_EXEC:   state_q <= S_WB;
        S_MULT:   if (wb_go) state_q <= S_WB;
        S_WB: begin
          state_q  <= S_DONE;
          done_q   <= 1'b1;
          branch_q <= br_d;
          err_q    <= op_q > OP_BLT;
        end
        default:  state_q <= S_IDLE;
      endcase
    end
  end
  assign busy     = state_q != S_IDLE;
  assign rd_we    = rd_we_q;
  assign rd_waddr = rd_waddr_q;
  assign rd_wdata = rd_wdata_q;
  assign branch   = branch_q;
  assign done     = done_q;
  assign err      = err_q;
endmodule
